// File: rtl/mem_stage_if.sv
// Memory request/acknowledge port between the memory stage and the data memory.
// The stage drives the request side; the memory answers with ack and read data.
interface mem_stage_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Fourth pipeline stage: passes ALU results to the register file and performs
// data-memory loads/stores over a req/ack port, stalling upstream while an
// access is outstanding and flagging accesses that never get acknowledged.
module mem_stage #(
    parameter int          DATA_W  = 16,
    parameter int          REG_AW  = 3,
    parameter int          TIMEOUT = 15,
    parameter logic [3:0]  OP_ADD  = 4'h0,
    parameter logic [3:0]  OP_SUB  = 4'hf,
    parameter logic [3:0]  OP_NOP  = 4'h2,
    parameter logic [3:0]  OP_LD   = 4'h8,
    parameter logic [3:0]  OP_ST   = 4'h9
) (
    input  logic              clk,
    input  logic              cpu_reset_n,

    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_value,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              stall,

    mem_stage_if.master       mem,

    output logic              wb_enable,
    output logic [REG_AW-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_value,

    output logic              mem_error,
    output logic [15:0]       mem_op_count
);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              state;
    state_t              state_next;

    logic                is_load;
    logic [REG_AW-1:0]   dest_q;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [7:0]          wait_count;

    logic                start_access;
    logic                access_done;
    logic                access_expired;

    // The bus request and the upstream stall are both just "an access is open".
    assign stall         = (state == MEM_WAIT);
    assign mem.mem_req   = (state == MEM_WAIT);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Classify the current cycle: a new access starting, finishing, or giving up.
    always_comb begin
        start_access   = 1'b0;
        access_done    = 1'b0;
        access_expired = 1'b0;
        if (state == IDLE) begin
            start_access = (in_op == OP_LD) || (in_op == OP_ST);
        end else begin
            access_done    = mem.mem_ack;
            access_expired = !mem.mem_ack && (wait_count == WAIT_LAST);
        end
    end

    // Next-state logic; an ack on the expiry edge wins over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_access) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (access_done || access_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Access registers: latched at capture and held steady for the whole wait.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            is_load <= 1'b0;
            dest_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start_access) begin
            is_load <= (in_op == OP_LD);
            dest_q  <= in_dest;
            we_q    <= (in_op == OP_ST);
            addr_q  <= in_value;
            wdata_q <= in_store_data;
        end
    end

    // Wait counter: cleared when an access opens, counts unacknowledged cycles.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            wait_count <= '0;
        end else if (start_access) begin
            wait_count <= '0;
        end else if (state == MEM_WAIT && !mem.mem_ack && !access_expired) begin
            wait_count <= wait_count + 8'd1;
        end
    end

    // Register-file write port: ALU results from IDLE, load data after an ack.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            wb_enable <= 1'b0;
            wb_dest   <= '0;
            wb_value  <= '0;
        end else begin
            wb_enable <= 1'b0;
            if (state == IDLE) begin
                case (in_op)
                    OP_ADD, OP_SUB: begin
                        wb_enable <= 1'b1;
                        wb_dest   <= in_dest;
                        wb_value  <= in_value;
                    end
                    OP_NOP, OP_LD, OP_ST: begin
                        wb_enable <= 1'b0;
                    end
                    default: begin
                        wb_enable <= 1'b0;
                    end
                endcase
            end else if (access_done && is_load) begin
                wb_enable <= 1'b1;
                wb_dest   <= dest_q;
                wb_value  <= mem.mem_rdata;
            end
        end
    end

    // Completed-access counter and sticky timeout flag.
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            mem_op_count <= '0;
            mem_error    <= 1'b0;
        end else begin
            if (access_done) begin
                mem_op_count <= mem_op_count + 16'd1;
            end
            if (access_expired) begin
                mem_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage, directly downstream of the execute stage.
- Consumes the execute stage's op/dest/result and performs data-memory loads and stores through a req/ack port.
- Drives the register-file write port (dest, value, enable) from registered outputs.
- While a memory access is outstanding it stalls upstream; it also flags accesses that time out.

Parameters:
- DATA_W, 16, datapath and memory word width
- REG_AW, 3, register address width
- TIMEOUT, 15, max wait cycles for mem_ack before abort (1..255)
- OP_ADD, 4'h0, op code: ALU add result
- OP_SUB, 4'hf, op code: ALU subtract result
- OP_NOP, 4'h2, op code: no operation
- OP_LD, 4'h8, op code: load, mem[in_value] -> in_dest
- OP_ST, 4'h9, op code: store, in_store_data -> mem[in_value]

Ports:
- clk  in  1  stage clock, rising edge
- cpu_reset_n  in  1  asynchronous active-low reset
- in_op  in  4  op from execute stage
- in_dest  in  REG_AW  destination register
- in_value  in  DATA_W  ALU result, or effective address for LD/ST
- in_store_data  in  DATA_W  store data for ST
- stall  out  1  upstream must hold in_* and not advance
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  request complete; mem_rdata valid this cycle for reads
- mem_rdata  in  DATA_W  load data
- wb_enable  out  1  register write enable
- wb_dest  out  REG_AW  register write address
- wb_value  out  DATA_W  register write data
- mem_error  out  1  sticky: an access timed out
- mem_op_count  out  16  completed LD/ST count, wraps at 16'hFFFF -> 0

Behaviour:
- Clock and reset: one clock, clk. Reset cpu_reset_n is asynchronous, active-low.
- State machine: IDLE and MEM_WAIT.
- Reset values: state=IDLE, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_enable=0, wb_dest=0, wb_value=0, mem_error=0, mem_op_count=0, wait counter=0.
- stall = (state==MEM_WAIT), combinational.
- mem_req = (state==MEM_WAIT), combinational.
- mem_we, mem_addr, mem_wdata come from registers latched at capture and stay stable for the whole MEM_WAIT.
- IDLE, in_op ADD/SUB:
  - Next edge: wb_enable=1, wb_dest=in_dest, wb_value=in_value.
  - Latency 1 cycle.
- IDLE, in_op LD/ST:
  - Latch op, dest, addr=in_value, wdata=in_store_data; mem_we=1 for ST.
  - Go to MEM_WAIT, clear wait counter.
  - wb_enable=0 next cycle.
- IDLE, any other op (including NOP): wb_enable=0 next cycle.
- MEM_WAIT:
  - in_* are ignored (upstream is holding them).
  - wb_enable=0 every cycle except the one following an LD ack.
  - mem_ack sampled at each rising edge.
- mem_ack=1 in MEM_WAIT:
  - Next state IDLE; mem_op_count+1.
  - LD: next edge wb_enable=1, wb_dest=latched dest, wb_value=mem_rdata.
  - ST: wb_enable=0.
  - stall stays 1 during the ack cycle; the held upstream instruction is consumed in the following IDLE cycle.
- Load latency: capture edge + N wait cycles + 1.
  - Zero-wait memory (ack in first MEM_WAIT cycle) gives the LD writeback 2 cycles after capture.
- Timeout:
  - Wait counter increments each MEM_WAIT cycle without ack.
  - When counter==TIMEOUT-1 and no ack: next state IDLE, mem_req drops, mem_error<=1 (sticky until reset).
  - No writeback; mem_op_count unchanged.
  - Ack on the same edge as expiry counts as success.
- mem_ack outside MEM_WAIT is ignored.
- Dest 7 for LD: wb_enable still asserts; the register file discards writes to r7.
- Back-to-back: LD immediately followed by ADD gives ADD writeback one cycle after the LD writeback, with no bubble inserted beyond the stall.
- Reset asserted mid-access: immediate return to reset values, no writeback, mem_req drops asynchronously.

Test Plan:
- ADD, dest=3, value=16'h0042 in IDLE -> next cycle wb_enable=1, wb_dest=3, wb_value=16'h0042; stall never asserts.
- LD, dest=2, addr=16'h0010; memory acks 3 cycles after mem_req rises with rdata=16'hBEEF:
  - stall=1 and mem_req=1, mem_we=0, mem_addr=16'h0010 for 3 cycles.
  - Next cycle wb_enable=1, wb_dest=2, wb_value=16'hBEEF; mem_op_count=1.
- ST, addr=16'h0020, data=16'h1234 with zero-wait ack:
  - mem_req=1, mem_we=1, mem_wdata=16'h1234 for exactly 1 cycle.
  - wb_enable stays 0; mem_op_count increments.
- LD with mem_ack held 0 and TIMEOUT=15:
  - mem_req high exactly 15 cycles, then 0; mem_error=1 and stays 1.
  - No wb_enable pulse; a following ADD completes normally.
- LD, then ADD held upstream:
  - ADD writeback occurs exactly 1 cycle after the LD writeback.
  - ADD not executed twice (single wb pulse for its dest).
- cpu_reset_n pulsed low during MEM_WAIT -> mem_req, stall, wb_enable, mem_error, mem_op_count all 0 immediately; after release, a new ADD completes in 1 cycle.
